// File: rtl/serial_adder.sv
// Bit-serial adder that processes one operand bit per clock, LSB first.
// It uses a single full-adder cell and a carry flip-flop, and presents a registered sum with a done pulse.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_sh_reg, a_sh_next;
   logic [WIDTH-1:0] b_sh_reg, b_sh_next;
   logic [WIDTH-1:0] psum_reg, psum_next;
   logic [WIDTH-1:0] sum_reg, sum_next;
   logic             cout_reg, cout_next;
   logic             carry_reg, carry_next;
   logic [CW-1:0]    count_reg, count_next;

   logic             bit_sum, bit_cout;
   logic [WIDTH-1:0] psum_shift;
   logic             ready;

   assign bit_sum  = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
   assign bit_cout = (a_sh_reg[0] & b_sh_reg[0]) | (carry_reg & (a_sh_reg[0] ^ b_sh_reg[0]));

   // The new sum bit enters at the MSB, so after WIDTH shifts bit 0 lands at position 0.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH - 1; gi++) begin : g_psum
         assign psum_shift[gi] = psum_reg[gi+1];
      end
   endgenerate
   assign psum_shift[WIDTH-1] = bit_sum;

   assign ready = (state_reg == IDLE) || (state_reg == DONE);

   always_comb begin
      state_next = state_reg;
      a_sh_next  = a_sh_reg;
      b_sh_next  = b_sh_reg;
      psum_next  = psum_reg;
      sum_next   = sum_reg;
      cout_next  = cout_reg;
      carry_next = carry_reg;
      count_next = count_reg;
      case (state_reg)
         IDLE, DONE: begin
            if (ready && start) begin
               a_sh_next  = a;
               b_sh_next  = b;
               carry_next = cin;
               psum_next  = '0;
               count_next = '0;
               state_next = SHIFT;
            end else begin
               state_next = IDLE;
            end
         end
         SHIFT: begin
            a_sh_next  = {1'b0, a_sh_reg[WIDTH-1:1]};
            b_sh_next  = {1'b0, b_sh_reg[WIDTH-1:1]};
            psum_next  = psum_shift;
            carry_next = bit_cout;
            if (count_reg == LAST) begin
               sum_next   = psum_shift;
               cout_next  = bit_cout;
               state_next = DONE;
            end else begin
               count_next = count_reg + CW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         a_sh_reg  <= '0;
         b_sh_reg  <= '0;
         psum_reg  <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
         carry_reg <= 1'b0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         a_sh_reg  <= a_sh_next;
         b_sh_reg  <= b_sh_next;
         psum_reg  <= psum_next;
         sum_reg   <= sum_next;
         cout_reg  <= cout_next;
         carry_reg <= carry_next;
         count_reg <= count_next;
      end
   end

   assign busy = (state_reg == SHIFT);
   assign done = (state_reg == DONE);
   assign sum  = sum_reg;
   assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at WIDTH=8.
// Covers latency, result hold, back-to-back accept and mid-operation reset.
module tb_serial_adder;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             busy, done, cout;
   logic [WIDTH-1:0] sum;

   int checks   = 0;
   int failures = 0;
   logic [WIDTH-1:0] last_sum  = '0;
   logic             last_cout = 1'b0;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Waits out the bit phase (holding start as left by the caller, scrambling a/b),
   // then checks the done cycle. Returns at the negedge where done is seen.
   task automatic wait_result(input string tag, input logic [WIDTH-1:0] es, input logic ec,
                              input bit scramble);
      for (int i = 0; i < WIDTH; i++) begin
         @(negedge clk);
         check({tag, " busy/done"}, {62'd0, busy, done}, 64'b10);
         check({tag, " hold"}, {55'd0, cout, sum}, {55'd0, last_cout, last_sum});
         if (scramble) begin
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = 1'($urandom);
         end
      end
      @(negedge clk);
      check({tag, " done"}, {62'd0, busy, done}, 64'b01);
      check({tag, " result"}, {55'd0, cout, sum}, {55'd0, ec, es});
      last_sum  = es;
      last_cout = ec;
      $display("op %s: sum=0x%02h cout=%0d (exp 0x%02h %0d)", tag, sum, cout, es, ec);
   endtask

   // Called just after a negedge with the DUT ready.
   task automatic run_op(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic vc, input logic [WIDTH-1:0] es, input logic ec);
      a = va; b = vb; cin = vc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_result(tag, es, ec, 1'b1);
      @(negedge clk);
      check({tag, " no double done"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      logic             rc;
      logic [WIDTH:0]   rexp;
      bit               saw_done;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset busy", {63'd0, busy}, 64'd0);
      check("reset done", {63'd0, done}, 64'd0);
      check("reset sum",  {56'd0, sum},  64'd0);
      check("reset cout", {63'd0, cout}, 64'd0);

      run_op("3C+0F",   8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
      run_op("FF+01",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run_op("A5+5A+1", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
      run_op("00+00",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      run_op("3C+0F b", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);

      // Start held high throughout; the DONE cycle accepts the next operands.
      a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      wait_result("12+34 held", 8'h46, 1'b0, 1'b1);
      a = 8'h77; b = 8'h11; cin = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_result("77+11+1 b2b", 8'h89, 1'b0, 1'b1);
      @(negedge clk);
      check("b2b no double done", {63'd0, done}, 64'd0);

      // Reset in the middle of 0xF0+0x0F aborts the operation.
      a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort busy", {63'd0, busy}, 64'd0);
      check("abort done", {63'd0, done}, 64'd0);
      check("abort sum",  {56'd0, sum},  64'd0);
      check("abort cout", {63'd0, cout}, 64'd0);
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check("abort no done", {63'd0, saw_done}, 64'd0);
      $display("op abort F0+0F: sum=0x%02h cout=%0d", sum, cout);
      last_sum  = '0;
      last_cout = 1'b0;
      run_op("after abort", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);

      for (int n = 0; n < 1000; n++) begin
         ra   = WIDTH'($urandom);
         rb   = WIDTH'($urandom);
         rc   = 1'($urandom);
         rexp = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
         run_op($sformatf("rnd%0d %02h+%02h+%0d", n, ra, rb, rc), ra, rb, rc,
                rexp[WIDTH-1:0], rexp[WIDTH]);
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check("idle done", {63'd0, done}, 64'd0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
